seq_detector_param: RTL and testbench

Parametrised, runtime-programmable serial bit-pattern detector, successor to the fixed 1101 detector. It compares a stream of qualified input bits against a loaded pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping detection and raises a one-cycle `detected` pulse per match. A saturating match counter is included. It sits between a serial front end (UART/line decoder) and control logic that needs a framing or marker event.

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_det_sat_counter.sv | 36 +++
 rtl/seq_detector_param.sv | 88 ++++++++
 tb/tb_seq_detector_param.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// width helper, power-on configuration defaults and the pattern-length mask.
package seq_det_pkg;

  localparam int MASK_MAX_W = 64;

  localparam logic [MASK_MAX_W-1:0] DEF_RST_PATTERN = 64'b1101;
  localparam int                    DEF_RST_LEN     = 4;
  localparam bit                    DEF_RST_OVERLAP = 1'b1;

  function automatic int lenWidth(input int maxLen);
    return $clog2(maxLen + 1);
  endfunction

  // Low 'len' bits set; callers truncate to their pattern width.
  function automatic logic [MASK_MAX_W-1:0] lenMask(input int len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment leaves the count at 1.
module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clr) begin
      w_count_next = i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_count != '1)) begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: holds the active config, the
// bit history and fill level, and raises a registered pulse per match.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   MAX_LEN     = 8,
  parameter int                   CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                   RST_LEN     = DEF_RST_LEN,
  parameter bit                   RST_OVERLAP = DEF_RST_OVERLAP,
  localparam int                  LEN_W       = lenWidth(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_detected;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_accept;
  logic               w_match;

  assign w_accept      = in_valid && !cfg_load;
  assign w_hist_next   = {r_hist[MAX_LEN-2:0], in_bit};
  assign w_fill_inc    = (r_fill == MAX_LEN_L) ? r_fill : r_fill + LEN_W'(1);
  assign w_mask        = MAX_LEN'(lenMask(int'(r_len)));
  assign w_len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

  // A zero length leaves the mask empty, so the explicit len check is what disables matching.
  assign w_match = w_accept && (r_len != '0) && (w_fill_inc >= r_len) &&
                   ((w_hist_next & w_mask) == (r_pat & w_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat      <= RST_PATTERN;
      r_len      <= LEN_W'(RST_LEN);
      r_ovl      <= RST_OVERLAP;
      r_hist     <= '0;
      r_fill     <= '0;
      r_detected <= 1'b0;
    end else if (cfg_load) begin
      r_pat      <= cfg_pattern;
      r_len      <= w_len_clamped;
      r_ovl      <= cfg_overlap;
      r_hist     <= '0;
      r_fill     <= '0;
      r_detected <= 1'b0;
    end else if (in_valid) begin
      r_hist     <= w_hist_next;
      r_fill     <= (w_match && !r_ovl) ? '0 : w_fill_inc;
      r_detected <= w_match;
    end else begin
      r_detected <= 1'b0;
    end
  end

  seq_det_sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_match),
    .i_clr  (cnt_clr),
    .o_count(match_count)
  );

  assign detected = r_detected;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with a 2-bit counter
// shares the stimulus so saturation can be observed.
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       detected;
  logic [15:0] match_count;
  logic       detected2;
  logic [1:0] match_count2;

  int vectorCount;
  int missCount;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .detected(detected), .match_count(match_count)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .detected(detected2), .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the active edge.
  task automatic applyStimulus(input logic v, input logic b, input logic ld,
                               input logic [7:0] pat, input logic [3:0] len,
                               input logic ovl, input logic clr);
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    applyStimulus(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic clearCount();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
  endtask

  // Sends n bits MSB first; expPulse holds the expected detected value after each bit.
  task automatic sendStream(input string tag, input logic [31:0] bits, input int n,
                            input logic [31:0] expPulse);
    for (int i = n - 1; i >= 0; i--) begin
      sendBit(bits[i]);
      checkOutput($sformatf("%s[%0d]", tag, n - 1 - i), {31'd0, detected}, {31'd0, expPulse[i]});
    end
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_detected", {31'd0, detected}, 32'd0);
    checkOutput("rst_count", {16'd0, match_count}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] default config, overlapping 1101");
    sendStream("ovl", 32'b1101101, 7, 32'b0001001);
    checkOutput("ovl_count", {16'd0, match_count}, 32'd2);

    $display("[TB] non-overlapping 1101");
    clearCount();
    checkOutput("clr_alone", {16'd0, match_count}, 32'd0);
    loadCfg(8'b00001101, 4'd4, 1'b0);
    checkOutput("load_det", {31'd0, detected}, 32'd0);
    sendStream("novl", 32'b1101101, 7, 32'b0001000);
    checkOutput("novl_count", {16'd0, match_count}, 32'd1);

    $display("[TB] gapped bits then mid-stream reload");
    loadCfg(8'b00001101, 4'd4, 1'b0);
    sendBit(1'b1); idleCycle();
    sendBit(1'b1); idleCycle();
    sendBit(1'b0); idleCycle();
    sendBit(1'b1);
    checkOutput("gap_pulse", {31'd0, detected}, 32'd1);
    idleCycle();
    checkOutput("gap_pulse_end", {31'd0, detected}, 32'd0);
    sendStream("pre", 32'b11, 2, 32'b00);
    loadCfg(8'b10101010, 4'd8, 1'b0);
    sendStream("len8", 32'b10101010, 8, 32'b00000001);
    checkOutput("len8_count", {16'd0, match_count}, 32'd3);

    $display("[TB] len 1, saturation and clear");
    clearCount();
    checkOutput("sat_clr", {30'd0, match_count2}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'b00000001, 4'd1, 1'b1, 1'b0);
    checkOutput("load_discard", {31'd0, detected}, 32'd0);
    sendStream("len1", 32'b11111, 5, 32'b11111);
    checkOutput("sat_count2", {30'd0, match_count2}, 32'd3);
    checkOutput("sat_count16", {16'd0, match_count}, 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    checkOutput("clr_inc_det", {31'd0, detected}, 32'd1);
    checkOutput("clr_inc_cnt2", {30'd0, match_count2}, 32'd1);
    checkOutput("clr_inc_cnt16", {16'd0, match_count}, 32'd1);
    clearCount();
    checkOutput("clr_only_cnt2", {30'd0, match_count2}, 32'd0);
    idleCycle();
    checkOutput("len1_idle", {31'd0, detected}, 32'd0);

    $display("[TB] reset mid-pattern");
    loadCfg(8'b00001101, 4'd4, 1'b1);
    sendStream("part", 32'b110, 3, 32'b000);
    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_cnt", {16'd0, match_count}, 32'd0);
    rst_n = 1'b1;
    sendStream("after_rst", 32'b11101, 5, 32'b00001);
    checkOutput("after_rst_cnt", {16'd0, match_count}, 32'd1);

    $display("[TB] zero length and clamped length");
    loadCfg(8'b00000000, 4'd0, 1'b1);
    sendStream("len0", 32'b11010110110101101101, 20, 32'd0);
    loadCfg(8'b11001010, 4'd15, 1'b0);
    sendStream("len15", 32'b11001010, 8, 32'b00000001);
    checkOutput("len15_count", {16'd0, match_count}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
